// File: rtl/sram_tiled_pkg.sv
// sram_tiled_pkg
// Shared constants and types for the tiled SRAM wrapper.
//   MACRO_W / MACRO_DEPTH : geometry of one sky130 32x512 macro
//   MACRO_AW / MACRO_NB   : row-address width and byte lanes of one macro
//   clr_state_t           : zero-fill controller state
package sram_tiled_pkg;

    localparam int MACRO_W     = 32;
    localparam int MACRO_DEPTH = 512;
    localparam int MACRO_AW    = $clog2(MACRO_DEPTH);
    localparam int MACRO_NB    = MACRO_W / 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clr_state_t;

endpackage

// File: rtl/sky130_sram_2kbyte_1rw1r_32x512_8.sv
// sky130_sram_2kbyte_1rw1r_32x512_8
// Behavioural stand-in for the 2 KB sky130 SRAM macro (32 bits x 512 words).
//   clk0/csb0/web0/wmask0/addr0/din0/dout0 : read-write port, active-low selects,
//                                            per-byte write mask
//   clk1/csb1/addr1/dout1                  : read-only port, active-low select
// Reads are synchronous: the word addressed at a rising edge appears on dout
// after that edge and holds until the next enabled read. A read and a write to
// the same row on the same edge return the old contents.
module sky130_sram_2kbyte_1rw1r_32x512_8 (
    input  logic        clk0,
    input  logic        csb0,
    input  logic        web0,
    input  logic [3:0]  wmask0,
    input  logic [8:0]  addr0,
    input  logic [31:0] din0,
    output logic [31:0] dout0,
    input  logic        clk1,
    input  logic        csb1,
    input  logic [8:0]  addr1,
    output logic [31:0] dout1
);

    logic [31:0] mem [0:511];

    always_ff @(posedge clk0) begin
        if (!csb0) begin
            if (!web0) begin
                for (int b = 0; b < 4; b++) begin
                    if (wmask0[b]) begin
                        mem[addr0][b*8 +: 8] <= din0[b*8 +: 8];
                    end
                end
            end else begin
                dout0 <= mem[addr0];
            end
        end
    end

    always_ff @(posedge clk1) begin
        if (!csb1) begin
            dout1 <= mem[addr1];
        end
    end

endmodule

// File: rtl/sram_tiled_bank.sv
// sram_tiled_bank
// One bank row of the tiled memory: LANES macros side by side, each covering
// 32 bits of the data word. Port 0 of every macro is used write-only, port 1
// read-only.
//   clock   : shared clock for both macro ports
//   we      : write this bank at wr_row
//   wr_row  : row address for the write
//   wr_data : full-width write data
//   wr_mask : full-width byte enables, four per lane
//   re      : read this bank at rd_row
//   rd_row  : row address for the read
//   rd_data : full-width macro read output (valid the cycle after re)
module sram_tiled_bank
    import sram_tiled_pkg::*;
#(
    parameter int LANES = 1
) (
    input  logic                        clock,
    input  logic                        we,
    input  logic [MACRO_AW-1:0]         wr_row,
    input  logic [LANES*MACRO_W-1:0]    wr_data,
    input  logic [LANES*MACRO_NB-1:0]   wr_mask,
    input  logic                        re,
    input  logic [MACRO_AW-1:0]         rd_row,
    output logic [LANES*MACRO_W-1:0]    rd_data
);

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        // Port 0 never reads, so its output has no consumer.
        logic [MACRO_W-1:0] dout0_unused;

        sky130_sram_2kbyte_1rw1r_32x512_8 u_macro (
            .clk0   (clock),
            .csb0   (~we),
            .web0   (~we),
            .wmask0 (wr_mask[l*MACRO_NB +: MACRO_NB]),
            .addr0  (wr_row),
            .din0   (wr_data[l*MACRO_W +: MACRO_W]),
            .dout0  (dout0_unused),
            .clk1   (clock),
            .csb1   (~re),
            .addr1  (rd_row),
            .dout1  (rd_data[l*MACRO_W +: MACRO_W])
        );
    end

endmodule

// File: rtl/sram_tiled_mem.sv
// sram_tiled_mem
// DATA_W x DEPTH memory built from BANKS x LANES sky130 32x512 macros, with a
// one-write / one-read port pair, two-cycle registered reads and a hardware
// zero-fill sequencer.
//   clock, reset_n      : clock and asynchronous active-low reset
//   W0_addr/en/data/mask: write port, byte enables W0_mask[i] -> byte i
//   R0_addr/en          : read request
//   R0_data/R0_valid    : read result, valid for one cycle two edges after
//                         the request edge; R0_data holds otherwise
//   clr_req             : start zero-filling every word
//   clr_busy            : zero-fill in progress; W0/R0 requests are dropped
// Build option: define SRAM_TILED_BYPASS_EN to forward write data into a read
// of the same address issued on the same edge. Without it such a read returns
// unspecified data (valid timing is unchanged) and no bypass register exists.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | normal read/write service
// ST_CLEAR | writing zeros to row cnt of every bank, cnt = 0..511
module sram_tiled_mem
    import sram_tiled_pkg::*;
#(
    parameter  int DATA_W = 32,
    parameter  int DEPTH  = 512,
    localparam int AW     = $clog2(DEPTH),
    localparam int LANES  = DATA_W / MACRO_W,
    localparam int BANKS  = DEPTH / MACRO_DEPTH
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [AW-1:0]       W0_addr,
    input  logic                W0_en,
    input  logic [DATA_W-1:0]   W0_data,
    input  logic [DATA_W/8-1:0] W0_mask,
    input  logic [AW-1:0]       R0_addr,
    input  logic                R0_en,
    output logic [DATA_W-1:0]   R0_data,
    output logic                R0_valid,
    input  logic                clr_req,
    output logic                clr_busy
);

    localparam int NB = DATA_W / 8;
    localparam int BW = (BANKS > 1) ? $clog2(BANKS) : 1;

    clr_state_t            state;
    clr_state_t            state_nxt;
    logic [MACRO_AW-1:0]   cnt;
    logic                  clr_start;

    logic                  wr_ok;
    logic                  rd_ok;
    logic [BW-1:0]         w_bank;
    logic [BW-1:0]         r_bank;

    logic [BANKS-1:0]      bank_we;
    logic [MACRO_AW-1:0]   wr_row;
    logic [DATA_W-1:0]     wr_data;
    logic [NB-1:0]         wr_mask;
    logic [DATA_W-1:0]     bank_dout [BANKS];

    logic                  rd_v1;
    logic                  rd_v2;
    logic [BW-1:0]         rd_bank_q;
    logic [DATA_W-1:0]     rd_mux;
    logic [DATA_W-1:0]     rd_merged;
    logic [DATA_W-1:0]     rd_stage;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (clr_req) state_nxt = ST_CLEAR;
            ST_CLEAR: if (cnt == MACRO_AW'(MACRO_DEPTH - 1)) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        clr_busy  = 1'b0;
        clr_start = 1'b0;
        case (state)
            ST_IDLE:  clr_start = clr_req;
            ST_CLEAR: clr_busy  = 1'b1;
            default:  ;
        endcase
    end

    // Row counter for the fill; wraps back to 0 on the final write.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clr_busy) begin
            cnt <= cnt + MACRO_AW'(1);
        end else begin
            cnt <= '0;
        end
    end

    // ------------------------------------------------------ request gating
    // A request sampled on the same edge that accepts clr_req is dropped too.
    assign wr_ok = W0_en & ~clr_busy & ~clr_start;
    assign rd_ok = R0_en & ~clr_busy & ~clr_start;

    if (BANKS > 1) begin : g_multi_bank
        assign w_bank = W0_addr[AW-1:MACRO_AW];
        assign r_bank = R0_addr[AW-1:MACRO_AW];
    end else begin : g_single_bank
        assign w_bank = '0;
        assign r_bank = '0;
    end

    // -------------------------------------------------------- write steering
    always_comb begin
        wr_row  = W0_addr[MACRO_AW-1:0];
        wr_data = W0_data;
        wr_mask = W0_mask;
        bank_we = '0;
        if (clr_busy) begin
            wr_row  = cnt;
            wr_data = '0;
            wr_mask = '1;
            bank_we = '1;
        end else if (wr_ok) begin
            bank_we[w_bank] = 1'b1;
        end
    end

    for (genvar b = 0; b < BANKS; b++) begin : g_bank
        sram_tiled_bank #(
            .LANES (LANES)
        ) u_bank (
            .clock   (clock),
            .we      (bank_we[b]),
            .wr_row  (wr_row),
            .wr_data (wr_data),
            .wr_mask (wr_mask),
            .re      (rd_ok),
            .rd_row  (R0_addr[MACRO_AW-1:0]),
            .rd_data (bank_dout[b])
        );
    end

    // --------------------------------------------------------- read pipeline
    // The bank select travels with the request, so a new R0_addr on the next
    // cycle cannot steer an older read.
    assign rd_mux = bank_dout[rd_bank_q];

`ifdef SRAM_TILED_BYPASS_EN
    logic              byp_hit;
    logic [DATA_W-1:0] byp_data;
    logic [NB-1:0]     byp_mask;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            byp_hit  <= 1'b0;
            byp_data <= '0;
            byp_mask <= '0;
        end else begin
            byp_hit <= rd_ok & wr_ok & (R0_addr == W0_addr);
            if (rd_ok & wr_ok & (R0_addr == W0_addr)) begin
                byp_data <= W0_data;
                byp_mask <= W0_mask;
            end
        end
    end

    // The macro returned the pre-write word; overlay the bytes just written.
    always_comb begin
        rd_merged = rd_mux;
        if (byp_hit) begin
            for (int i = 0; i < NB; i++) begin
                if (byp_mask[i]) begin
                    rd_merged[i*8 +: 8] = byp_data[i*8 +: 8];
                end
            end
        end
    end
`else
    assign rd_merged = rd_mux;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_v1     <= 1'b0;
            rd_bank_q <= '0;
            rd_v2     <= 1'b0;
            rd_stage  <= '0;
            R0_valid  <= 1'b0;
            R0_data   <= '0;
        end else begin
            rd_v1 <= rd_ok;
            if (rd_ok) begin
                rd_bank_q <= r_bank;
            end
            rd_v2 <= rd_v1;
            if (rd_v1) begin
                rd_stage <= rd_merged;
            end
            R0_valid <= rd_v2;
            if (rd_v2) begin
                R0_data <= rd_stage;
            end
        end
    end

endmodule

// File: tb/tb_sram_tiled_mem.sv
module tb_sram_tiled_mem;

    localparam int DATA_W = 64;
    localparam int DEPTH  = 1024;
    localparam int AW     = 10;

    logic              clock;
    logic              reset_n;
    logic [AW-1:0]     W0_addr;
    logic              W0_en;
    logic [DATA_W-1:0] W0_data;
    logic [7:0]        W0_mask;
    logic [AW-1:0]     R0_addr;
    logic              R0_en;
    logic [DATA_W-1:0] R0_data;
    logic              R0_valid;
    logic              clr_req;
    logic              clr_busy;

    int errors = 0;
    int checks = 0;

    sram_tiled_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .W0_addr  (W0_addr),
        .W0_en    (W0_en),
        .W0_data  (W0_data),
        .W0_mask  (W0_mask),
        .R0_addr  (R0_addr),
        .R0_en    (R0_en),
        .R0_data  (R0_data),
        .R0_valid (R0_valid),
        .clr_req  (clr_req),
        .clr_busy (clr_busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [63:0] pat(input int a);
        return {32'hC0DE_0000 | 32'(a), ~(32'(a) * 32'h0000_9E37)};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [63:0] d, input logic [7:0] m);
        @(negedge clock);
        W0_en = 1'b1; W0_addr = a; W0_data = d; W0_mask = m;
        @(negedge clock);
        W0_en = 1'b0;
    endtask

    // Read at edge N; valid low after N and N+1, high after N+2, low and held after N+3.
    task automatic read_chk(input string tag, input logic [AW-1:0] a, input logic [63:0] exp);
        @(negedge clock);
        R0_en = 1'b1; R0_addr = a;
        @(negedge clock);
        R0_en = 1'b0;
        chk({tag, "_v_n0"}, 64'(R0_valid), 64'd0);
        @(negedge clock);
        chk({tag, "_v_n1"}, 64'(R0_valid), 64'd0);
        @(negedge clock);
        chk({tag, "_v_n2"}, 64'(R0_valid), 64'd1);
        chk({tag, "_data"}, R0_data, exp);
        @(negedge clock);
        chk({tag, "_v_n3"}, 64'(R0_valid), 64'd0);
        chk({tag, "_hold"}, R0_data, exp);
    endtask

    task automatic collide(input string tag, input logic [63:0] d, input logic [7:0] m,
                           input logic [63:0] exp);
        @(negedge clock);
        W0_en = 1'b1; W0_addr = 10'd9; W0_data = d; W0_mask = m;
        R0_en = 1'b1; R0_addr = 10'd9;
        @(negedge clock);
        W0_en = 1'b0; R0_en = 1'b0;
        chk({tag, "_v_n0"}, 64'(R0_valid), 64'd0);
        @(negedge clock);
        chk({tag, "_v_n1"}, 64'(R0_valid), 64'd0);
        @(negedge clock);
        chk({tag, "_v_n2"}, 64'(R0_valid), 64'd1);
`ifdef SRAM_TILED_BYPASS_EN
        chk({tag, "_data"}, R0_data, exp);
`endif
        @(negedge clock);
        chk({tag, "_v_n3"}, 64'(R0_valid), 64'd0);
    endtask

    initial begin
        int busy_cycles;
        logic saw_valid;

        reset_n = 1'b0;
        W0_addr = '0; W0_en = 1'b0; W0_data = '0; W0_mask = '0;
        R0_addr = '0; R0_en = 1'b0; clr_req = 1'b0;

        repeat (3) @(negedge clock);
        chk("rst_valid", 64'(R0_valid), 64'd0);
        chk("rst_data",  R0_data,        64'd0);
        chk("rst_busy",  64'(clr_busy),  64'd0);
        reset_n = 1'b1;

        // basic write/read in bank 1
        do_write(10'd700, 64'hDEADBEEF_01234567, 8'hFF);
        read_chk("rd700", 10'd700, 64'hDEADBEEF_01234567);

        // byte masking, then an all-zero mask write that changes nothing
        do_write(10'd3, 64'h00000000_FFFFFFFF, 8'hFF);
        do_write(10'd3, 64'h00000000_00000000, 8'h05);
        read_chk("mask", 10'd3, 64'h00000000_FF00FF00);
        do_write(10'd3, 64'hFFFFFFFF_FFFFFFFF, 8'h00);
        read_chk("mask0", 10'd3, 64'h00000000_FF00FF00);

        // reset during a fill at cnt = 100
        @(negedge clock);
        clr_req = 1'b1;
        @(negedge clock);
        clr_req = 1'b0;
        repeat (100) @(negedge clock);
        chk("pre_rst_busy", 64'(clr_busy), 64'd1);
        reset_n = 1'b0;
        #1;
        chk("midrst_busy",  64'(clr_busy), 64'd0);
        chk("midrst_valid", 64'(R0_valid), 64'd0);
        chk("midrst_data",  R0_data,        64'd0);
        @(negedge clock);
        reset_n = 1'b1;
        repeat (3) @(negedge clock);
        chk("postrst_idle", 64'(clr_busy), 64'd0);
        do_write(10'd800, 64'h0BAD_F00D_1357_9BDF, 8'hFF);
        read_chk("postrst_rd", 10'd800, 64'h0BAD_F00D_1357_9BDF);

        // fill every word with a known pattern, then stream it back
        for (int a = 0; a < DEPTH; a++) begin
            @(negedge clock);
            W0_en = 1'b1; W0_addr = AW'(a); W0_data = pat(a); W0_mask = 8'hFF;
        end
        @(negedge clock);
        W0_en = 1'b0;

        for (int k = 0; k < DEPTH + 3; k++) begin
            @(negedge clock);
            if (k >= 3) begin
                chk("stream_valid", 64'(R0_valid), 64'd1);
                chk("stream_data",  R0_data,        pat(k - 3));
            end else begin
                chk("stream_pre", 64'(R0_valid), 64'd0);
            end
            if (k < DEPTH) begin
                R0_en = 1'b1; R0_addr = AW'(k);
            end else begin
                R0_en = 1'b0;
            end
        end
        @(negedge clock);
        chk("stream_post", 64'(R0_valid), 64'd0);

        // zero-fill: a read in flight completes, a read on the accept edge is
        // dropped, and writes/reads/clr_req during the fill are ignored
        @(negedge clock);
        R0_en = 1'b1; R0_addr = 10'd700;
        @(negedge clock);
        R0_addr = 10'd3; clr_req = 1'b1;
        @(negedge clock);
        clr_req = 1'b0; R0_en = 1'b0;
        busy_cycles = 0;
        saw_valid = 1'b0;
        while (clr_busy && busy_cycles < 600) begin
            busy_cycles++;
            if (busy_cycles == 2) begin
                chk("inflight_valid", 64'(R0_valid), 64'd1);
                chk("inflight_data",  R0_data,        pat(700));
            end else if (R0_valid) begin
                saw_valid = 1'b1;
            end
            case (busy_cycles)
                200: begin
                    W0_en = 1'b1; W0_addr = 10'd10; W0_data = '1; W0_mask = 8'hFF;
                    R0_en = 1'b1; R0_addr = 10'd10;
                end
                201: begin W0_en = 1'b0; R0_en = 1'b0; end
                300: clr_req = 1'b1;
                301: clr_req = 1'b0;
                default: ;
            endcase
            @(negedge clock);
        end
        chk("clr_len",      64'(busy_cycles), 64'd512);
        chk("clr_no_valid", 64'(saw_valid),   64'd0);

        for (int k = 0; k < DEPTH + 3; k++) begin
            @(negedge clock);
            if (k >= 3) begin
                chk("zero_valid", 64'(R0_valid), 64'd1);
                chk("zero_data",  R0_data,        64'd0);
            end
            if (k < DEPTH) begin
                R0_en = 1'b1; R0_addr = AW'(k);
            end else begin
                R0_en = 1'b0;
            end
        end
        @(negedge clock);
        chk("zero_post_busy", 64'(clr_busy), 64'd0);

        // read/write collisions on addr 9 (zero after the fill)
        collide("coll_full", 64'h00000000_A5A5A5A5, 8'hFF, 64'h00000000_A5A5A5A5);
        collide("coll_part", 64'hFFFFFFFF_00000000, 8'hF0, 64'hFFFFFFFF_A5A5A5A5);
        read_chk("coll_after", 10'd9, 64'hFFFFFFFF_A5A5A5A5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
